// File: rtl/dp_ctrl_pkg.sv
// Shared constants for the datapath sequencer: widths, instruction field
// positions, opcode values and FSM state encoding.
package dp_ctrl_pkg;

    localparam int DATA_W    = 8;
    localparam int ALU_SEL_W = 5;
    localparam int INSTR_W   = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int REG_BIT = 12;
    localparam int RSV_MSB = 11;
    localparam int RSV_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int ALU_MSB = 4;
    localparam int ALU_LSB = 0;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_PSHI = 3'd2;
    localparam logic [2:0] OP_POPR = 3'd3;
    localparam logic [2:0] OP_ALU  = 3'd4;
    localparam logic [2:0] OP_ALUR = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/dp_instr_decode.sv
// Combinational field extraction for one micro-instruction word, plus the
// two op-class flags the sequencer keys its hold registers on.
module dp_instr_decode
    import dp_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0]   i_ir,
    output logic [2:0]           o_op,
    output logic                 o_reg_tgt,
    output logic [DATA_W-1:0]    o_imm,
    output logic [ALU_SEL_W-1:0] o_alu_sel,
    output logic                 o_reg_load,
    output logic                 o_alu_op
);

    // Bits [11:8] carry no meaning for any opcode.
    logic [RSV_MSB-RSV_LSB:0] w_unused_rsvd;

    assign o_op          = i_ir[OPC_MSB:OPC_LSB];
    assign o_reg_tgt     = i_ir[REG_BIT];
    assign o_imm         = i_ir[IMM_MSB:IMM_LSB];
    assign o_alu_sel     = i_ir[ALU_MSB:ALU_LSB];
    assign o_reg_load    = (o_op == OP_LDI) || (o_op == OP_POPR) || (o_op == OP_ALUR);
    assign o_alu_op      = (o_op == OP_ALU) || (o_op == OP_ALUR);
    assign w_unused_rsvd = i_ir[RSV_MSB:RSV_LSB];

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-instruction sequencer for the 8-bit register/ALU/stack datapath.
// IDLE -> EXEC [-> WB] -> IDLE; every instruction retires with a done pulse.
module datapath_sequencer
    import dp_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic                 carry_flag,
    output logic                 reg_sel,
    output logic                 reg_we,
    output logic [DATA_W-1:0]    reg_din,
    output logic [ALU_SEL_W-1:0] alu_sel,
    input  logic [DATA_W-1:0]    alu_output,
    input  logic                 alu_carry,
    output logic                 stack_push,
    output logic                 stack_pop,
    output logic                 stack_rstn,
    output logic [DATA_W-1:0]    stack_din,
    input  logic [DATA_W-1:0]    stack_dout,
    input  logic                 stack_full,
    input  logic                 stack_empty,
    output logic [1:0]           dbg_state
);

    // Handshake: a word transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready stays low until the done cycle
    // has passed, so a held instr_valid is only taken again from IDLE.
    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [INSTR_W-1:0]     r_ir;
    logic [INSTR_W-1:0]     w_ir_src;
    logic                   r_reg_sel;
    logic [ALU_SEL_W-1:0]   r_alu_sel;
    logic [DATA_W-1:0]      r_reg_din;
    logic [DATA_W-1:0]      r_stack_din;
    logic                   r_err;
    logic                   r_carry;

    logic [2:0]             w_op;
    logic                   w_reg_tgt;
    logic [DATA_W-1:0]      w_imm;
    logic [ALU_SEL_W-1:0]   w_alu_sel;
    logic                   w_reg_load;
    logic                   w_alu_op;
    logic                   w_accept;
    logic                   w_exec;
    logic                   w_wb;
    logic                   w_clr_pulse;
    logic                   w_err_set;

    // In IDLE decode the word on the bus so hold registers load at accept.
    assign w_ir_src = (r_state == ST_IDLE) ? instr : r_ir;

    dp_instr_decode u_decode (
        .i_ir       (w_ir_src),
        .o_op       (w_op),
        .o_reg_tgt  (w_reg_tgt),
        .o_imm      (w_imm),
        .o_alu_sel  (w_alu_sel),
        .o_reg_load (w_reg_load),
        .o_alu_op   (w_alu_op)
    );

    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_exec   = (r_state == ST_EXEC);
    assign w_wb     = (r_state == ST_WB);

    always_comb begin
        w_state_nxt = r_state;
        reg_we      = 1'b0;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        done        = 1'b0;
        w_clr_pulse = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_IDLE;
                done        = 1'b1;
                case (w_op)
                    OP_LDI:  reg_we = 1'b1;
                    OP_PSHI: begin
                        if (stack_full) w_err_set  = 1'b1;
                        else            stack_push = 1'b1;
                    end
                    OP_POPR: begin
                        if (stack_empty) begin
                            w_err_set = 1'b1;
                        end else begin
                            stack_pop   = 1'b1;
                            done        = 1'b0;
                            w_state_nxt = ST_WB;
                        end
                    end
                    OP_ALU, OP_ALUR: begin
                        done        = 1'b0;
                        w_state_nxt = ST_WB;
                    end
                    OP_CLR:  w_clr_pulse = 1'b1;
                    OP_ILL:  w_err_set   = 1'b1;
                    default: ;
                endcase
            end
            ST_WB: begin
                w_state_nxt = ST_IDLE;
                done        = 1'b1;
                case (w_op)
                    OP_POPR, OP_ALUR: reg_we = 1'b1;
                    OP_ALU: begin
                        if (stack_full) w_err_set  = 1'b1;
                        else            stack_push = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_ir <= instr;
        end
    end

    // ALU results are captured at the end of EXEC, after alu_sel has been
    // stable for the whole cycle; the write itself happens in WB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_reg_sel   <= 1'b0;
            r_alu_sel   <= '0;
            r_reg_din   <= '0;
            r_stack_din <= '0;
        end else begin
            if (w_accept) begin
                if (w_reg_load)         r_reg_sel   <= w_reg_tgt;
                if (w_alu_op)           r_alu_sel   <= w_alu_sel;
                if (w_op == OP_LDI)     r_reg_din   <= w_imm;
                if (w_op == OP_PSHI)    r_stack_din <= w_imm;
            end
            if (w_exec && (w_op == OP_ALUR)) r_reg_din   <= alu_output;
            if (w_exec && (w_op == OP_ALU))  r_stack_din <= alu_output;
            if (w_wb && (w_op == OP_POPR))   r_reg_din   <= stack_dout;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err   <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            if (w_err_set)        r_err <= 1'b1;
            else if (w_clr_pulse) r_err <= 1'b0;
            if (w_clr_pulse)           r_carry <= 1'b0;
            else if (w_wb && w_alu_op) r_carry <= alu_carry;
        end
    end

    // Popped data only appears the cycle after the pop, so pass it straight through in WB.
    assign reg_din     = (w_wb && (w_op == OP_POPR)) ? stack_dout : r_reg_din;
    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;
    assign carry_flag  = r_carry;
    assign reg_sel     = r_reg_sel;
    assign alu_sel     = r_alu_sel;
    assign stack_din   = r_stack_din;
    assign stack_rstn  = rstn & ~w_clr_pulse;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small register/ALU/stack
// model standing in for the datapath.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready, done, busy, err, carry_flag;
    logic        reg_sel, reg_we, stack_push, stack_pop, stack_rstn;
    logic [7:0]  reg_din, stack_din, alu_output;
    logic [7:0]  stack_dout;
    logic [4:0]  alu_sel;
    logic        alu_carry, stack_full, stack_empty;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .busy        (busy),
        .err         (err),
        .carry_flag  (carry_flag),
        .reg_sel     (reg_sel),
        .reg_we      (reg_we),
        .reg_din     (reg_din),
        .alu_sel     (alu_sel),
        .alu_output  (alu_output),
        .alu_carry   (alu_carry),
        .stack_push  (stack_push),
        .stack_pop   (stack_pop),
        .stack_rstn  (stack_rstn),
        .stack_din   (stack_din),
        .stack_dout  (stack_dout),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .dbg_state   (dbg_state)
    );

    // Datapath model: two registers, a 4-deep stack, add/and ALU.
    logic [7:0] m_r0 = 8'h00;
    logic [7:0] m_r1 = 8'h00;
    logic [7:0] m_stk [4];
    logic [2:0] m_sp;

    always @(posedge clk or negedge stack_rstn) begin
        if (!stack_rstn) begin
            m_sp       <= 3'd0;
            stack_dout <= 8'h00;
        end else if (stack_push && (m_sp < 3'd4)) begin
            m_stk[m_sp[1:0]] <= stack_din;
            m_sp             <= m_sp + 3'd1;
        end else if (stack_pop && (m_sp > 3'd0)) begin
            stack_dout <= m_stk[m_sp[1:0] - 2'd1];
            m_sp       <= m_sp - 3'd1;
        end
    end

    assign stack_full  = (m_sp == 3'd4);
    assign stack_empty = (m_sp == 3'd0);

    always @(posedge clk) begin
        if (reg_we) begin
            if (reg_sel) m_r1 <= reg_din;
            else         m_r0 <= reg_din;
        end
    end

    always_comb begin
        alu_carry  = 1'b0;
        alu_output = m_r0;
        case (alu_sel)
            5'd0: {alu_carry, alu_output} = {1'b0, m_r0} + {1'b0, m_r1};
            5'd1: alu_output = m_r0 & m_r1;
            default: ;
        endcase
    end

    // Waits (bounded) for instr_ready, then presents w for one accept edge.
    task automatic send(input logic [15:0] w);
        int guard;
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: got %b exp 1 (instr %h)", instr_ready, w); end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
        n_tests++; if ({instr_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL rst_ready_busy: got %b exp 10", {instr_ready, busy}); end
        n_tests++; if ({done, reg_we, stack_push, stack_pop} !== 4'b0000) begin n_fail++; $display("FAIL rst_pulses: got %b exp 0000", {done, reg_we, stack_push, stack_pop}); end
        n_tests++; if (stack_rstn !== 1'b0) begin n_fail++; $display("FAIL rst_stack_rstn: got %b exp 0", stack_rstn); end
        n_tests++; if ({err, carry_flag, reg_sel} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {err, carry_flag, reg_sel}); end
        n_tests++; if ({reg_din, stack_din, alu_sel} !== 21'd0) begin n_fail++; $display("FAIL rst_data: got %h/%h/%h exp 0", reg_din, stack_din, alu_sel); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_tests++; if (stack_rstn !== 1'b1) begin n_fail++; $display("FAIL rst_release: got %b exp 1", stack_rstn); end
    endtask

    task automatic test_ldi();
        send(16'h2012);
        @(negedge clk);
        n_tests++; if ({reg_we, reg_sel, done} !== 3'b101) begin n_fail++; $display("FAIL ldi0_ctrl: got %b exp 101", {reg_we, reg_sel, done}); end
        n_tests++; if (reg_din !== 8'h12) begin n_fail++; $display("FAIL ldi0_din: got %h exp 12", reg_din); end
        n_tests++; if ({instr_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL ldi0_busy: got %b exp 01", {instr_ready, busy}); end
        @(negedge clk);
        n_tests++; if ({reg_we, done} !== 2'b00) begin n_fail++; $display("FAIL ldi0_single: got %b exp 00", {reg_we, done}); end
        n_tests++; if (reg_din !== 8'h12) begin n_fail++; $display("FAIL ldi0_hold: got %h exp 12", reg_din); end
        send(16'h3034);
        @(negedge clk);
        n_tests++; if ({reg_we, reg_sel, done} !== 3'b111) begin n_fail++; $display("FAIL ldi1_ctrl: got %b exp 111", {reg_we, reg_sel, done}); end
        n_tests++; if (reg_din !== 8'h34) begin n_fail++; $display("FAIL ldi1_din: got %h exp 34", reg_din); end
    endtask

    task automatic test_push_pop();
        send(16'h40A5);
        @(negedge clk);
        n_tests++; if ({stack_push, done} !== 2'b11) begin n_fail++; $display("FAIL pshi_ctrl: got %b exp 11", {stack_push, done}); end
        n_tests++; if (stack_din !== 8'hA5) begin n_fail++; $display("FAIL pshi_din: got %h exp a5", stack_din); end
        send(16'h7000);
        @(negedge clk);
        n_tests++; if ({stack_pop, reg_we, done} !== 3'b100) begin n_fail++; $display("FAIL popr_exec: got %b exp 100", {stack_pop, reg_we, done}); end
        @(negedge clk);
        n_tests++; if ({stack_pop, reg_we, reg_sel, done} !== 4'b0111) begin n_fail++; $display("FAIL popr_wb: got %b exp 0111", {stack_pop, reg_we, reg_sel, done}); end
        n_tests++; if (reg_din !== 8'hA5) begin n_fail++; $display("FAIL popr_din: got %h exp a5", reg_din); end
    endtask

    task automatic test_alu();
        send(16'h20F0);
        send(16'h3020);
        send(16'hB001);
        @(negedge clk);
        n_tests++; if (alu_sel !== 5'd1) begin n_fail++; $display("FAIL alur_sel: got %0d exp 1", alu_sel); end
        n_tests++; if ({reg_we, done} !== 2'b00) begin n_fail++; $display("FAIL alur_exec: got %b exp 00", {reg_we, done}); end
        @(negedge clk);
        n_tests++; if ({reg_we, reg_sel, done} !== 3'b111) begin n_fail++; $display("FAIL alur_wb: got %b exp 111", {reg_we, reg_sel, done}); end
        n_tests++; if (reg_din !== 8'h20) begin n_fail++; $display("FAIL alur_din: got %h exp 20", reg_din); end
        send(16'h8000);
        @(negedge clk);
        n_tests++; if ({alu_sel, stack_push, done} !== 7'b0000000) begin n_fail++; $display("FAIL alu_exec: got %b exp 0000000", {alu_sel, stack_push, done}); end
        @(negedge clk);
        n_tests++; if ({stack_push, reg_we, done} !== 3'b101) begin n_fail++; $display("FAIL alu_wb: got %b exp 101", {stack_push, reg_we, done}); end
        n_tests++; if (stack_din !== 8'h10) begin n_fail++; $display("FAIL alu_din: got %h exp 10", stack_din); end
        @(negedge clk);
        n_tests++; if (carry_flag !== 1'b1) begin n_fail++; $display("FAIL alu_carry: got %b exp 1", carry_flag); end
    endtask

    task automatic test_empty_pop_clr();
        send(16'hC000);
        @(negedge clk);
        n_tests++; if ({stack_rstn, done} !== 2'b01) begin n_fail++; $display("FAIL clr_exec: got %b exp 01", {stack_rstn, done}); end
        @(negedge clk);
        n_tests++; if ({stack_rstn, carry_flag, err} !== 3'b100) begin n_fail++; $display("FAIL clr_after: got %b exp 100", {stack_rstn, carry_flag, err}); end
        send(16'h6000);
        @(negedge clk);
        n_tests++; if ({stack_pop, reg_we, done} !== 3'b001) begin n_fail++; $display("FAIL empty_pop: got %b exp 001", {stack_pop, reg_we, done}); end
        @(negedge clk);
        n_tests++; if ({err, dbg_state} !== 3'b100) begin n_fail++; $display("FAIL empty_err: got %b exp 100", {err, dbg_state}); end
        send(16'hC000);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b exp 0", err); end
    endtask

    task automatic test_full_ill();
        for (int i = 0; i < 4; i++) begin
            send(16'h4000 | 16'(i + 1));
            @(negedge clk);
            n_tests++; if ({stack_push, stack_din} !== {1'b1, 8'(i + 1)}) begin n_fail++; $display("FAIL fill_%0d: got %b/%h exp 1/%h", i, stack_push, stack_din, i + 1); end
        end
        send(16'h40EE);
        @(negedge clk);
        n_tests++; if ({stack_push, done} !== 2'b01) begin n_fail++; $display("FAIL full_push: got %b exp 01", {stack_push, done}); end
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL full_err: got %b exp 1", err); end
        send(16'h2055);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", err); end
        send(16'hC000);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL clr2_err: got %b exp 0", err); end
        send(16'hE000);
        @(negedge clk);
        n_tests++; if ({reg_we, stack_push, stack_pop, stack_rstn, done} !== 5'b00011) begin n_fail++; $display("FAIL ill_exec: got %b exp 00011", {reg_we, stack_push, stack_pop, stack_rstn, done}); end
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b exp 1", err); end
    endtask

    task automatic test_back_to_back();
        int acc, dn, we, guard;
        acc = 0; dn = 0; we = 0; guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        instr       = 16'h2077;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) instr_valid = 1'b0;
            #1;
            if (instr_valid && instr_ready) acc++;
            if (done)   dn++;
            if (reg_we) we++;
            @(negedge clk);
        end
        n_tests++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d exp 3", acc); end
        n_tests++; if (dn !== 3) begin n_fail++; $display("FAIL b2b_done: got %0d exp 3", dn); end
        n_tests++; if (we !== 3) begin n_fail++; $display("FAIL b2b_reg_we: got %0d exp 3", we); end
    endtask

    task automatic test_reset_mid_wb();
        send(16'h405A);
        send(16'h7000);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if ({dbg_state, reg_we} !== 3'b101) begin n_fail++; $display("FAIL midwb_pre: got %b exp 101", {dbg_state, reg_we}); end
        rstn = 1'b0;
        #1;
        n_tests++; if ({dbg_state, instr_ready, busy} !== 4'b0010) begin n_fail++; $display("FAIL midwb_state: got %b exp 0010", {dbg_state, instr_ready, busy}); end
        n_tests++; if ({done, reg_we, stack_push, stack_pop, stack_rstn} !== 5'b00000) begin n_fail++; $display("FAIL midwb_pulses: got %b exp 00000", {done, reg_we, stack_push, stack_pop, stack_rstn}); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_tests++; if ({done, busy, err} !== 3'b000) begin n_fail++; $display("FAIL midwb_after: got %b exp 000", {done, busy, err}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ldi();
        test_push_pop();
        test_alu();
        test_empty_pop_clr();
        test_full_ill();
        test_back_to_back();
        test_reset_mid_wb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
